// File: rtl/uart_frame_sequencer.sv
// Parses A5-framed command packets from the UART byte stream, applies audio
// configuration, and drains validated stream payloads over a valid/ready port.
module uart_frame_sequencer #(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 260417
) (
   input  logic       CLK50MHz,
   input  logic       RST_N,
   input  logic [7:0] RX_DATA,
   input  logic       RX_VALID,
   input  logic       RX_FERR,
   output logic [7:0] CFG_VOL,
   output logic       CFG_MUTE,
   output logic [7:0] SAMPLE,
   output logic       SAMPLE_VALID,
   input  logic       SAMPLE_READY,
   output logic       PKT_OK,
   output logic       PKT_ERR,
   output logic       OVERRUN,
   output logic       BUSY
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [7:0]    SYNC       = 8'hA5;
   localparam logic [7:0]    CMD_VOL    = 8'h01;
   localparam logic [7:0]    CMD_MUTE   = 8'h02;
   localparam logic [7:0]    CMD_STREAM = 8'h10;
   localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
   localparam logic [IW-1:0] LEN_ONE    = IW'(1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_LEN,
      GET_PAY,
      GET_CHK,
      DRAIN
   } state_t;

   state_t        state_q;
   logic [7:0]    cmd_q;
   logic [7:0]    chk_q;
   logic [IW-1:0] len_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] rd_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    buf_q [MAX_LEN];

   logic [7:0]    chk_d;
   logic [IW-1:0] idx_d;
   logic          pay_wr;

   assign chk_d  = chk_q ^ RX_DATA;
   assign idx_d  = idx_q + 1'b1;
   assign pay_wr = (state_q == GET_PAY) && RX_VALID && !RX_FERR;
   assign BUSY   = (state_q != IDLE);

   // Payload storage carries no reset; the index/state reset is what discards it.
   always_ff @(posedge CLK50MHz) begin
      if (pay_wr) begin
         buf_q[idx_q[AW-1:0]] <= RX_DATA;
      end
   end

   always_ff @(posedge CLK50MHz or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         chk_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         rd_q         <= '0;
         tmo_q        <= '0;
         CFG_VOL      <= 8'h80;
         CFG_MUTE     <= 1'b1;
         SAMPLE       <= '0;
         SAMPLE_VALID <= 1'b0;
         PKT_OK       <= 1'b0;
         PKT_ERR      <= 1'b0;
         OVERRUN      <= 1'b0;
      end else begin
         PKT_OK  <= 1'b0;
         PKT_ERR <= 1'b0;
         OVERRUN <= 1'b0;
         case (state_q)
            IDLE: begin
               tmo_q <= '0;
               if (RX_VALID && (RX_DATA == SYNC)) begin
                  state_q <= GET_CMD;
               end
            end

            GET_CMD, GET_LEN, GET_PAY, GET_CHK: begin
               if (RX_VALID) begin
                  tmo_q <= '0;
                  if (RX_FERR) begin
                     PKT_ERR <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     case (state_q)
                        GET_CMD: begin
                           cmd_q   <= RX_DATA;
                           chk_q   <= RX_DATA;
                           state_q <= GET_LEN;
                        end
                        GET_LEN: begin
                           chk_q <= chk_d;
                           idx_q <= '0;
                           if (RX_DATA > MAX_LEN_B) begin
                              PKT_ERR <= 1'b1;
                              state_q <= IDLE;
                           end else begin
                              len_q   <= RX_DATA[IW-1:0];
                              state_q <= (RX_DATA == 8'h00) ? GET_CHK : GET_PAY;
                           end
                        end
                        GET_PAY: begin
                           chk_q <= chk_d;
                           idx_q <= idx_d;
                           if (idx_d == len_q) begin
                              state_q <= GET_CHK;
                           end
                        end
                        GET_CHK: begin
                           state_q <= IDLE;
                           // A correct checksum XORs the running sum to zero.
                           if (chk_d != 8'h00) begin
                              PKT_ERR <= 1'b1;
                           end else if ((cmd_q == CMD_VOL) && (len_q == LEN_ONE)) begin
                              CFG_VOL <= buf_q[0];
                              PKT_OK  <= 1'b1;
                           end else if ((cmd_q == CMD_MUTE) && (len_q == LEN_ONE)) begin
                              CFG_MUTE <= buf_q[0][0];
                              PKT_OK   <= 1'b1;
                           end else if ((cmd_q == CMD_STREAM) && (len_q != '0)) begin
                              PKT_OK       <= 1'b1;
                              SAMPLE       <= buf_q[0];
                              SAMPLE_VALID <= 1'b1;
                              rd_q         <= LEN_ONE;
                              state_q      <= DRAIN;
                           end else begin
                              PKT_ERR <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end else if (tmo_q == TO_LAST) begin
                  PKT_ERR <= 1'b1;
                  tmo_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            DRAIN: begin
               if (RX_VALID) begin
                  OVERRUN <= 1'b1;
               end
               // rd_q is the index of the next byte to present; equal to len means the last is out.
               if (SAMPLE_READY) begin
                  if (rd_q == len_q) begin
                     SAMPLE_VALID <= 1'b0;
                     state_q      <= IDLE;
                  end else begin
                     SAMPLE <= buf_q[rd_q[AW-1:0]];
                     rd_q   <= rd_q + 1'b1;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: table of framed packets plus hand-written
// drain, timeout and asynchronous-reset sequences, with a sample scoreboard.
module tb_uart_frame_sequencer;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic       sample_ready;
   logic [7:0] cfg_vol;
   logic       cfg_mute;
   logic [7:0] sample;
   logic       sample_valid;
   logic       pkt_ok;
   logic       pkt_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int ok_cnt = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   logic [7:0] sb_q[$];
   logic       prev_hold = 1'b0;
   logic [7:0] prev_s = 8'h00;

   uart_frame_sequencer #(.MAX_LEN(16), .TIMEOUT_CYC(TO)) dut (
      .CLK50MHz    (clk),
      .RST_N       (rst_n),
      .RX_DATA     (rx_data),
      .RX_VALID    (rx_valid),
      .RX_FERR     (rx_ferr),
      .CFG_VOL     (cfg_vol),
      .CFG_MUTE    (cfg_mute),
      .SAMPLE      (sample),
      .SAMPLE_VALID(sample_valid),
      .SAMPLE_READY(sample_ready),
      .PKT_OK      (pkt_ok),
      .PKT_ERR     (pkt_err),
      .OVERRUN     (overrun),
      .BUSY        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic f);
      @(posedge clk); #1;
      rx_data  = d;
      rx_valid = 1'b1;
      rx_ferr  = f;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
   endtask

   // Pulse counters, OK/ERR exclusivity, hold stability and sample scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pkt_ok)  ok_cnt++;
         if (pkt_err) err_cnt++;
         if (overrun) ovr_cnt++;
         if (pkt_ok || pkt_err) check("ok_err_excl", 32'(pkt_ok && pkt_err), 0);
         if (prev_hold) begin
            check("hold_valid", 32'(sample_valid), 1);
            check("hold_data", 32'(sample), 32'(prev_s));
         end
         if (sample_valid && sample_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 32'(sample), 32'hFFFF);
            end else begin
               check("sb_sample", 32'(sample), 32'(sb_q.pop_front()));
            end
         end
         prev_hold = sample_valid && !sample_ready;
         prev_s    = sample;
      end else begin
         prev_hold = 1'b0;
      end
   end

   typedef struct {
      logic [63:0] bytes;
      int          n;
      logic [7:0]  ferr;
      int          eok;
      int          eerr;
      logic [7:0]  evol;
      logic        emute;
   } vec_t;

   localparam int NV = 12;
   vec_t vec [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ok0, err0, ovr0;
      logic [7:0] exp_s [5];
      logic       exp_v [5];
      logic       pat   [5];

      vec[0]  = '{64'h00_00_00_41_40_01_01_A5, 5, 8'h00, 0, 1, 8'h80, 1'b1};
      vec[1]  = '{64'h00_00_00_40_40_01_01_A5, 5, 8'h00, 1, 0, 8'h40, 1'b1};
      vec[2]  = '{64'h00_00_00_00_00_11_01_A5, 3, 8'h00, 0, 1, 8'h40, 1'b1};
      vec[3]  = '{64'h00_00_00_00_00_00_66_55, 2, 8'h00, 0, 0, 8'h40, 1'b1};
      vec[4]  = '{64'h00_00_00_00_01_01_02_A5, 4, 8'h08, 0, 1, 8'h40, 1'b1};
      vec[5]  = '{64'h00_00_00_03_00_01_02_A5, 5, 8'h00, 1, 0, 8'h40, 1'b0};
      vec[6]  = '{64'h00_00_00_00_07_00_07_A5, 4, 8'h00, 0, 1, 8'h40, 1'b0};
      vec[7]  = '{64'h00_00_33_20_10_02_01_A5, 6, 8'h00, 0, 1, 8'h40, 1'b0};
      vec[8]  = '{64'h00_00_00_00_10_00_10_A5, 4, 8'h00, 0, 1, 8'h40, 1'b0};
      vec[9]  = '{64'h00_00_00_A5_A5_01_01_A5, 5, 8'h00, 1, 0, 8'hA5, 1'b0};
      vec[10] = '{64'h00_00_00_02_01_01_02_A5, 5, 8'h00, 1, 0, 8'hA5, 1'b1};
      vec[11] = '{64'h00_00_00_FD_FE_01_02_A5, 5, 8'h00, 1, 0, 8'hA5, 1'b0};

      rst_n        = 1'b0;
      rx_data      = 8'h00;
      rx_valid     = 1'b0;
      rx_ferr      = 1'b0;
      sample_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vol", 32'(cfg_vol), 32'h80);
      check("rst_mute", 32'(cfg_mute), 1);
      check("rst_svalid", 32'(sample_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pulses", 32'({pkt_ok, pkt_err, overrun}), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         ok0  = ok_cnt;
         err0 = err_cnt;
         for (int j = 0; j < vec[i].n; j++) begin
            send_byte(vec[i].bytes[8*j +: 8], vec[i].ferr[j]);
         end
         check($sformatf("v%0d_ok_lat", i), 32'(pkt_ok), 32'(vec[i].eok != 0));
         check($sformatf("v%0d_err_lat", i), 32'(pkt_err), 32'(vec[i].eerr != 0));
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_ok_cnt", i), 32'(ok_cnt - ok0), 32'(vec[i].eok));
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt - err0), 32'(vec[i].eerr));
         check($sformatf("v%0d_vol", i), 32'(cfg_vol), 32'(vec[i].evol));
         check($sformatf("v%0d_mute", i), 32'(cfg_mute), 32'(vec[i].emute));
         check($sformatf("v%0d_busy", i), 32'(busy), 0);
      end

      // Stream drain with ready pattern 1,0,0,1,1 and a stray byte mid-drain.
      ok0  = ok_cnt;
      ovr0 = ovr_cnt;
      sb_q.push_back(8'h11);
      sb_q.push_back(8'h22);
      sb_q.push_back(8'h33);
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_s = '{8'h22, 8'h22, 8'h22, 8'h33, 8'h33};
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      send_byte(8'hA5, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h13, 1'b0);
      check("drn_first_s", 32'(sample), 32'h11);
      check("drn_first_v", 32'(sample_valid), 1);
      check("drn_ok_lat", 32'(pkt_ok), 1);
      for (int k = 0; k < 5; k++) begin
         sample_ready = pat[k];
         if (k == 1) begin
            rx_data  = 8'hA5;
            rx_valid = 1'b1;
         end
         @(posedge clk); #1;
         rx_valid = 1'b0;
         check($sformatf("drn%0d_v", k), 32'(sample_valid), 32'(exp_v[k]));
         if (exp_v[k]) check($sformatf("drn%0d_s", k), 32'(sample), 32'(exp_s[k]));
      end
      sample_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("drn_sb_empty", 32'(sb_q.size()), 0);
      check("drn_ovr_cnt", 32'(ovr_cnt - ovr0), 1);
      check("drn_ok_cnt", 32'(ok_cnt - ok0), 1);
      check("drn_busy", 32'(busy), 0);

      // A byte landing exactly on the timeout cycle wins over the timeout.
      ok0  = ok_cnt;
      err0 = err_cnt;
      send_byte(8'hA5, 1'b0);
      repeat (TO - 2) @(posedge clk);
      send_byte(8'h01, 1'b0);
      check("race_no_err", 32'(pkt_err), 0);
      check("race_busy", 32'(busy), 1);
      send_byte(8'h01, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h77, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("race_ok_cnt", 32'(ok_cnt - ok0), 1);
      check("race_err_cnt", 32'(err_cnt - err0), 0);
      check("race_vol", 32'(cfg_vol), 32'h77);

      // Plain timeout after A5 01, then a mute frame recovers.
      err0 = err_cnt;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      repeat (TO - 1) @(posedge clk);
      #1;
      check("to_early_err", 32'(pkt_err), 0);
      check("to_early_busy", 32'(busy), 1);
      @(posedge clk); #1;
      check("to_err", 32'(pkt_err), 1);
      check("to_busy", 32'(busy), 0);
      repeat (TO + 5) @(posedge clk);
      #1;
      check("to_err_cnt", 32'(err_cnt - err0), 1);
      ok0 = ok_cnt;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("to_mute_ok", 32'(ok_cnt - ok0), 1);
      check("to_mute", 32'(cfg_mute), 0);

      // Asynchronous reset in the middle of a drain.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'h03, 1'b0);
      check("ar_pre_v", 32'(sample_valid), 1);
      check("ar_pre_busy", 32'(busy), 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("ar_svalid", 32'(sample_valid), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_vol", 32'(cfg_vol), 32'h80);
      check("ar_mute", 32'(cfg_mute), 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("ar_post_v", 32'(sample_valid), 0);
      check("ar_post_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
